// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
// Optional feature macro: MEM_PORT_ARBITER_SIGNEXT_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    localparam logic [31:0] ZeroWord = 32'h0;
    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    function automatic logic [2:0] len_bytes(
        input logic [1:0] len
    );
        logic [2:0] n;
        unique case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and RAM-side byte port of the arbiter.
// slave = arbiter view, master = core/RAM environment view.
interface mem_port_arbiter_if #(
    parameter int RAM_AW = 17
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic              mem_signed;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_len,
        input  mem_signed, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_data,
        output mem_done, mem_rdata,
        output ram_addr, ram_dout, ram_wr,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_len,
        output mem_signed, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_data,
        input  mem_done, mem_rdata,
        input  ram_addr, ram_dout, ram_wr,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_byte_assemble.sv
// Little-endian byte insert into a 32-bit word.
// MEM_PORT_ARBITER_SIGNEXT_EN adds byte/half sign extension.
module mem_byte_assemble
    import mem_port_arbiter_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  idx,
    input  logic [1:0]  len,
    input  logic        sext,
    output logic [31:0] word_out
);

    logic [31:0] ins;

    always_comb begin
        ins = word_in;
        unique case (idx)
            2'd0:    ins[7:0]   = byte_in;
            2'd1:    ins[15:8]  = byte_in;
            2'd2:    ins[23:16] = byte_in;
            default: ins[31:24] = byte_in;
        endcase
    end

`ifdef MEM_PORT_ARBITER_SIGNEXT_EN
    always_comb begin
        word_out = ins;
        if (sext && len == LEN_B)
            word_out = {{24{ins[7]}}, ins[7:0]};
        else if (sext && len == LEN_H)
            word_out = {{16{ins[15]}}, ins[15:0]};
    end
`else
    logic [2:0] unused_sx;
    assign unused_sx = {sext, len};
    assign word_out  = ins;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between fetch and load/store.
// Optional macro: MEM_PORT_ARBITER_SIGNEXT_EN (signed loads).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input logic              dclk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    state_t            state, state_n;
    req_t              who;
    logic [2:0]        cnt, cnt_n, nbytes;
    logic [RAM_AW-1:0] base;
    logic [1:0]        lenq;
    logic              sgn;
    logic [31:0]       wdata, asm_q, asm_nx;
    logic [31:0]       if_data_q, mem_rdata_q;
    logic [1:0]        idx;
    logic              accept, last_rd, active;
    logic              if_done, mem_done;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = Disable;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (bus.mem_req || bus.if_req) begin
                    accept  = Enable;
                    state_n = (bus.mem_req && bus.mem_we)
                            ? S_WR : S_RD;
                end
            end
            S_RD: begin
                cnt_n = cnt + 3'd1;
                if (cnt == nbytes)
                    state_n = S_DONE;
            end
            S_WR: begin
                cnt_n = cnt + 3'd1;
                if (cnt == nbytes - 3'd1)
                    state_n = S_DONE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // byte read at cnt-1 arrives while cnt is presented
    assign idx     = 2'(cnt - 3'd1);
    assign last_rd = (state == S_RD) && (cnt == nbytes);

    mem_byte_assemble u_asm (
        .word_in  (asm_q),
        .byte_in  (bus.ram_din),
        .idx      (idx),
        .len      (lenq),
        .sext     (sgn),
        .word_out (asm_nx)
    );

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            who         <= REQ_IF;
            base        <= '0;
            nbytes      <= 3'd4;
            lenq        <= LEN_W;
            sgn         <= Disable;
            wdata       <= ZeroWord;
            asm_q       <= ZeroWord;
            if_data_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                if (bus.mem_req) begin
                    who    <= REQ_MEM;
                    base   <= bus.mem_addr[RAM_AW-1:0];
                    nbytes <= len_bytes(bus.mem_len);
                    lenq   <= bus.mem_len;
                    sgn    <= bus.mem_signed;
                end else begin
                    who    <= REQ_IF;
                    base   <= bus.if_addr[RAM_AW-1:0];
                    nbytes <= 3'd4;
                    lenq   <= LEN_W;
                    sgn    <= Disable;
                end
                wdata <= bus.mem_wdata;
                asm_q <= ZeroWord;
            end else if (state == S_RD && cnt != 3'd0) begin
                asm_q <= asm_nx;
            end
            if (last_rd) begin
                if (who == REQ_IF)
                    if_data_q   <= asm_nx;
                else
                    mem_rdata_q <= asm_nx;
            end
        end
    end

    assign active = (state == S_RD) || (state == S_WR);

    assign bus.ram_addr = active
                        ? base + RAM_AW'(cnt) : '0;
    assign bus.ram_wr   = (state == S_WR);
    assign bus.ram_dout = (state == S_WR)
                        ? 8'(wdata >> {cnt[1:0], 3'b000})
                        : 8'h00;

    assign if_done  = (state == S_DONE) && (who == REQ_IF);
    assign mem_done = (state == S_DONE) && (who == REQ_MEM);

    assign bus.if_done   = if_done;
    assign bus.mem_done  = mem_done;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_done;
    assign bus.stall_mem = bus.mem_req & ~mem_done;

    logic unused_hi;
    assign unused_hi = ^{bus.if_addr[31:RAM_AW],
                         bus.mem_addr[31:RAM_AW]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Models a synchronous byte RAM with one-cycle read latency.
module tb_mem_port_arbiter;

    logic dclk = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.RAM_AW(17)) bus ();

    mem_port_arbiter #(.RAM_AW(17)) dut (
        .dclk (dclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 dclk = ~dclk;

    logic [7:0]  ram [0:131071];
    logic [7:0]  rd_q;
    logic        pl_we = 1'b0;
    logic [16:0] pl_a  = '0;
    logic [7:0]  pl_d  = '0;

    always @(posedge dclk) begin
        if (bus.ram_wr)
            ram[bus.ram_addr] <= bus.ram_dout;
        else if (pl_we)
            ram[pl_a] <= pl_d;
        rd_q <= ram[bus.ram_addr];
    end
    assign bus.ram_din = rd_q;

    // preload one RAM byte while the DUT is not writing
    task automatic poke(input logic [16:0] a,
                        input logic [7:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_we = 1'b1;
        @(negedge dclk);
        pl_we = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_len    = 2'b00;
        bus.mem_signed = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
    endtask

    task automatic test_reset();
        int k;
        idle_inputs();
        rst = 1'b1;
        @(negedge dclk);
        poke(17'h100, 8'h13);
        poke(17'h101, 8'h05);
        poke(17'h102, 8'h00);
        poke(17'h103, 8'h00);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge dclk);
        checks++;
        if (bus.ram_wr !== 1'b0) begin
            errors++;
            $display("FAIL rst_ram_wr got %b want 0", bus.ram_wr);
        end
        checks++;
        if (bus.ram_addr !== 17'h0) begin
            errors++;
            $display("FAIL rst_ram_addr got %h want 0",
                     bus.ram_addr);
        end
        checks++;
        if ({bus.if_done, bus.mem_done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_done got %b want 00",
                     {bus.if_done, bus.mem_done});
        end
        checks++;
        if ({bus.if_data, bus.mem_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL rst_data got %h want 0",
                     {bus.if_data, bus.mem_rdata});
        end
        checks++;
        if (bus.stall_if !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall_if got %b want 1",
                     bus.stall_if);
        end
        rst = 1'b0;
        k = 0;
        for (int c = 1; c <= 20 && k == 0; c++) begin
            @(negedge dclk);
            if (bus.if_done === 1'b1) k = c;
        end
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL fetch_latency got %0d want 6", k);
        end
        checks++;
        if (bus.if_data !== 32'h00000513) begin
            errors++;
            $display("FAIL fetch_data got %h want 00000513",
                     bus.if_data);
        end
        checks++;
        if (bus.stall_if !== 1'b0) begin
            errors++;
            $display("FAIL fetch_stall_at_done got %b want 0",
                     bus.stall_if);
        end
        bus.if_req = 1'b0;
        @(negedge dclk);
        checks++;
        if (bus.if_done !== 1'b0 ||
            bus.if_data !== 32'h00000513) begin
            errors++;
            $display("FAIL fetch_pulse_hold got %b/%h want 0/513",
                     bus.if_done, bus.if_data);
        end
    endtask

    task automatic test_store_word();
        logic [16:0] wa [4];
        logic [7:0]  wd [4];
        logic [31:0] exp_w;
        int nw, k;
        bit st_ok;
        nw = 0;
        k = 0;
        st_ok = 1'b1;
        exp_w = 32'hDEADBEEF;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'b10;
        bus.mem_addr  = 32'h20;
        bus.mem_wdata = exp_w;
        for (int c = 1; c <= 20 && k == 0; c++) begin
            @(negedge dclk);
            if (bus.ram_wr === 1'b1) begin
                if (nw < 4) begin
                    wa[nw] = bus.ram_addr;
                    wd[nw] = bus.ram_dout;
                end
                if (bus.stall_mem !== 1'b1) st_ok = 1'b0;
                nw++;
            end
            if (bus.mem_done === 1'b1) k = c;
        end
        checks++;
        if (nw != 4 || k != 5) begin
            errors++;
            $display("FAIL store_cycles got wr=%0d done@%0d want 4/5",
                     nw, k);
        end
        checks++;
        if (!st_ok) begin
            errors++;
            $display("FAIL store_stall got 0 want 1");
        end
        for (int i = 0; i < 4 && i < nw; i++) begin
            checks++;
            if (wa[i] !== 17'(32'h20 + i) ||
                wd[i] !== 8'(exp_w >> (8 * i))) begin
                errors++;
                $display("FAIL store_byte%0d got %h:%h want %h:%h",
                         i, wa[i], wd[i], 17'(32'h20 + i),
                         8'(exp_w >> (8 * i)));
            end
        end
        checks++;
        if ({ram[17'h23], ram[17'h22], ram[17'h21],
             ram[17'h20]} !== exp_w) begin
            errors++;
            $display("FAIL store_ram got %h%h%h%h want deadbeef",
                     ram[17'h23], ram[17'h22], ram[17'h21],
                     ram[17'h20]);
        end
        idle_inputs();
        @(negedge dclk);
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_m;
        int km, ki;
        bit st_ok, hold_ok;
`ifdef MEM_PORT_ARBITER_SIGNEXT_EN
        exp_m = 32'hFFFFFF80;
`else
        exp_m = 32'h00000080;
`endif
        poke(17'h7, 8'h80);
        poke(17'h200, 8'h78);
        poke(17'h201, 8'h56);
        poke(17'h202, 8'h34);
        poke(17'h203, 8'h12);
        km = 0;
        ki = 0;
        st_ok = 1'b1;
        hold_ok = 1'b1;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h200;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b0;
        bus.mem_len    = 2'b00;
        bus.mem_signed = 1'b1;
        bus.mem_addr   = 32'h7;
        for (int c = 1; c <= 40 && ki == 0; c++) begin
            @(negedge dclk);
            if (bus.if_done !== 1'b1 && bus.stall_if !== 1'b1)
                st_ok = 1'b0;
            if (bus.mem_done === 1'b1) begin
                km = c;
                checks++;
                if (bus.mem_rdata !== exp_m) begin
                    errors++;
                    $display("FAIL byte_load got %h want %h",
                             bus.mem_rdata, exp_m);
                end
                if (bus.if_data !== 32'h00000513) hold_ok = 1'b0;
                bus.mem_req = 1'b0;
            end
            if (bus.if_done === 1'b1) begin
                ki = c;
                checks++;
                if (bus.if_data !== 32'h12345678) begin
                    errors++;
                    $display("FAIL fetch2_data got %h want 12345678",
                             bus.if_data);
                end
            end
        end
        checks++;
        if (km != 3 || ki != 10) begin
            errors++;
            $display("FAIL arb_order got mem@%0d if@%0d want 3/10",
                     km, ki);
        end
        checks++;
        if (!st_ok) begin
            errors++;
            $display("FAIL arb_stall_if got 0 want 1");
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL if_data_hold got changed want 513");
        end
        idle_inputs();
        @(negedge dclk);
    endtask

    task automatic test_wrap();
        logic [16:0] a0, a1;
        int k;
        poke(17'h1FFFF, 8'hCD);
        poke(17'h00000, 8'hAB);
        k = 0;
        a0 = '0;
        a1 = '1;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b0;
        bus.mem_len    = 2'b01;
        bus.mem_signed = 1'b0;
        bus.mem_addr   = 32'h0003FFFF;
        for (int c = 1; c <= 20 && k == 0; c++) begin
            @(negedge dclk);
            if (c == 1) a0 = bus.ram_addr;
            if (c == 2) a1 = bus.ram_addr;
            if (bus.mem_done === 1'b1) k = c;
        end
        checks++;
        if (a0 !== 17'h1FFFF || a1 !== 17'h00000) begin
            errors++;
            $display("FAIL wrap_addr got %h,%h want 1ffff,00000",
                     a0, a1);
        end
        checks++;
        if (k != 4 || bus.mem_rdata !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL wrap_half got %h@%0d want 0000abcd@4",
                     bus.mem_rdata, k);
        end
        idle_inputs();
        @(negedge dclk);
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int i = 0; i < 4; i++)
            poke(17'(32'h40 + i), 8'h11);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'b10;
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'hA1B2C3D4;
        @(negedge dclk);
        @(negedge dclk);
        checks++;
        if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 17'h41) begin
            errors++;
            $display("FAIL wr2_cycle got %b/%h want 1/00041",
                     bus.ram_wr, bus.ram_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ram_wr !== 1'b0 || bus.mem_done !== 1'b0 ||
            bus.ram_addr !== 17'h0) begin
            errors++;
            $display("FAIL abort_now got wr=%b done=%b a=%h want 0",
                     bus.ram_wr, bus.mem_done, bus.ram_addr);
        end
        idle_inputs();
        @(negedge dclk);
        checks++;
        if ({ram[17'h43], ram[17'h42], ram[17'h41],
             ram[17'h40]} !== 32'h111111D4) begin
            errors++;
            $display("FAIL abort_ram got %h%h%h%h want 111111d4",
                     ram[17'h43], ram[17'h42], ram[17'h41],
                     ram[17'h40]);
        end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge dclk);
            if (bus.mem_done !== 1'b0 || bus.ram_wr !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles want 0",
                     bad);
        end
    endtask

    task automatic test_drop_req();
        int pulses, k;
        logic [31:0] got;
        pulses = 0;
        k = 0;
        got = '0;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b0;
        bus.mem_len    = 2'b11;
        bus.mem_signed = 1'b1;
        bus.mem_addr   = 32'h20;
        for (int c = 1; c <= 12; c++) begin
            @(negedge dclk);
            if (c == 2) bus.mem_req = 1'b0;
            if (bus.mem_done === 1'b1) begin
                pulses++;
                k = c;
                got = bus.mem_rdata;
            end
        end
        checks++;
        if (pulses != 1 || k != 6) begin
            errors++;
            $display("FAIL drop_req got %0d pulses@%0d want 1@6",
                     pulses, k);
        end
        checks++;
        if (got !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL drop_data got %h want deadbeef", got);
        end
        idle_inputs();
        @(negedge dclk);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_drop_req();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single byte-wide RAM port on the FPGA test build between instruction fetch (IF) and the load/store stage (MEM). It turns each 32-bit-level request into a sequence of byte accesses and assembles or splits the data little-endian. It raises stall requests that hold the IF and ID_EX/EX_MEM pipeline registers until the access completes. It sits between the core pipeline and the board RAM/UART bridge.

Parameters:
RAM_AW, 17, RAM byte-address width; upper request address bits are ignored.

Ports:
dclk  in  1  core clock
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held until if_done
if_addr  in  32  fetch byte address
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction word
mem_req  in  1  load/store request; held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_len  in  2  00 byte, 01 half, 10/11 word
mem_signed  in  1  load sign-extend select (used only with the optional feature)
mem_addr  in  32  load/store byte address
mem_wdata  in  32  store data, LSB-aligned
mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
mem_rdata  out  32  load data, zero-extended (see Optional Feature)
ram_addr  out  RAM_AW  RAM byte address
ram_dout  out  8  RAM write byte
ram_wr  out  1  RAM write strobe
ram_din  in  8  RAM read byte, valid one cycle after its address
stall_if  out  1  if_req & ~if_done (combinational)
stall_mem  out  1  mem_req & ~mem_done (combinational)

Behaviour:
- Reset: async, active-high. State IDLE, cnt=0, ram_addr=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0. Reset mid-transaction aborts it; ram_wr drops immediately and no done pulse is produced.
- States: IDLE, RD, WR, DONE.
- IDLE: mem_req wins over if_req. On accept, latch the requester, address, length N (1/2/4), we and wdata; cnt=0.
  - Load/fetch goes to RD.
  - Store goes to WR.
- RD:
  - Each cycle drive ram_addr = addr[RAM_AW-1:0] + cnt (wraps mod 2^RAM_AW).
  - Capture ram_din into byte cnt-1 of the assembly register when cnt ≥ 1.
  - The cycle that captures byte N-1 goes to DONE.
  - Latency: N+1 RD cycles after accept.
- WR:
  - ram_wr=1, ram_addr = addr + cnt, ram_dout = wdata byte cnt.
  - After byte N-1, go to DONE.
  - N WR cycles total.
- DONE:
  - Pulse if_done or mem_done for exactly one cycle.
  - if_data/mem_rdata update in the same cycle and hold until the next completion of that requester.
  - Return to IDLE.
  - New arbitration happens only in IDLE, so back-to-back requests have a 1-cycle gap.
- Byte order: little-endian; byte 0 goes to bits 7:0. Unread upper bytes are 0.
- Deasserting a req mid-transaction is ignored; the transaction completes and the done pulse is still issued.
- Simultaneous if_req and mem_req in IDLE: MEM is served first, then IF. stall_if stays high throughout.
- ram_wr is never high outside WR.

Optional Feature:
MEM_PORT_ARBITER_SIGNEXT_EN
- Defined: when mem_signed=1 on a byte or half load, mem_rdata is sign-extended from bit 7 or bit 15.
- Undefined: mem_signed is ignored and loads are always zero-extended; the EX/MEM stage extends instead.

Decomposition:
- Shared macro header: state encodings, length codes (`LEN_B`, `LEN_H`, `LEN_W`), `ZeroWord`, `Enable`/`Disable`.
- One sub-module, mem_byte_assemble: byte insert at index, plus the optional sign-extension.

Test Plan:
1. Reset with if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 05 00 00 → after release, if_done pulses on cycle 6 after accept (4+1 RD cycles, then DONE); if_data=0x00000513.
2. Store word: mem_we=1, mem_len=10, mem_addr=0x20, wdata=0xDEADBEEF → 4 ram_wr cycles with addresses 0x20..0x23 and data EF BE AD DE; mem_done pulses; RAM readback matches.
3. if_req and mem_req (byte load from 0x7, RAM=0x80) rise together → MEM served first, mem_rdata=0x00000080 (0xFFFFFF80 with SIGNEXT_EN and mem_signed=1); IF served after one idle cycle; stall_if high until its done.
4. Half load at 0x1FFFF with RAM_AW=17 → addresses 0x1FFFF then 0x00000 (wrap); result {RAM[0],RAM[0x1FFFF]}.
5. Assert rst during the 2nd WR cycle of a word store → ram_wr=0 immediately, no mem_done, state IDLE; only byte 0 was written.
6. Drop mem_req mid-load → transaction completes and mem_done still pulses once.
